// File: rtl/ascii_frame_decoder_pkg.sv
// ascii_frame_pkg
//   Shared definitions for the ASCII valve-pattern frame decoder and any later
//   command parsers that reuse the character classifier:
//   - 2-bit channel code values,
//   - err_cause encodings reported alongside frame_err,
//   - the decoder FSM state type.
package ascii_frame_pkg;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_MODE = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BADCHAR = 2'b01;
  localparam logic [1:0] ERR_LENGTH  = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/ascii_frame_decoder_if.sv
// ascii_frame_decoder_if
//   Byte-in / frame-out bundle of the ASCII frame decoder.
//   rx_data/rx_valid   : byte strobe from the UART receiver
//   frame_data/valid   : packed channel codes, held until frame_ready
//   frame_ready        : consumer acceptance
//   frame_err/err_cause: one-cycle discard pulse with its reason
//   modport slave  : decoder side
//   modport master : byte source / frame consumer side
interface ascii_frame_decoder_if #(
  parameter int NUM_CH = 8
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [2*NUM_CH-1:0] frame_data;
  logic                frame_valid;
  logic                frame_ready;
  logic                frame_err;
  logic [1:0]          err_cause;

  modport slave (
    input  rx_data, rx_valid, frame_ready,
    output frame_data, frame_valid, frame_err, err_cause
  );

  modport master (
    output rx_data, rx_valid, frame_ready,
    input  frame_data, frame_valid, frame_err, err_cause
  );
endinterface

// File: rtl/ascii_frame_decoder_char_classify.sv
// ascii_char_classify
//   Purely combinational byte classifier.
//   data    : input byte
//   is_skip : byte is the ignored character (CR by default)
//   is_term : byte is the line terminator (LF by default)
//   is_code : byte is '0', '1' or the mode character; code holds its value
//   is_bad  : any other byte
module ascii_char_classify
  import ascii_frame_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h0A,
  parameter logic [7:0] SKIP_CHAR = 8'h0D,
  parameter logic [7:0] MODE_CHAR = 8'h6D
) (
  input  logic [7:0] data,
  output logic       is_code,
  output logic       is_term,
  output logic       is_skip,
  output logic       is_bad,
  output logic [1:0] code
);

  always_comb begin
    is_code = 1'b0;
    is_term = 1'b0;
    is_skip = 1'b0;
    is_bad  = 1'b0;
    code    = CODE_ZERO;
    if (data == SKIP_CHAR) begin
      is_skip = 1'b1;
    end else if (data == TERM_CHAR) begin
      is_term = 1'b1;
    end else if (data == 8'h30) begin
      is_code = 1'b1;
      code    = CODE_ZERO;
    end else if (data == 8'h31) begin
      is_code = 1'b1;
      code    = CODE_ONE;
    end else if (data == MODE_CHAR) begin
      is_code = 1'b1;
      code    = CODE_MODE;
    end else begin
      is_bad = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_frame_decoder.sv
// ascii_frame_decoder
//   Decodes a UART byte stream of '0'/'1'/'m' characters into NUM_CH 2-bit
//   channel codes, one frame per terminated line, and hands each complete
//   frame to the valve sequencer over a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   fbus     : rx byte strobe in, frame/error reporting out (slave modport)
//   busy     : high whenever the decoder is not idle
module ascii_frame_decoder
  import ascii_frame_pkg::*;
#(
  parameter int         NUM_CH    = 8,
  parameter logic [7:0] TERM_CHAR = 8'h0A,
  parameter logic [7:0] SKIP_CHAR = 8'h0D,
  parameter logic [7:0] MODE_CHAR = 8'h6D
) (
  input  logic                  clk,
  input  logic                  rst,
  ascii_frame_decoder_if.slave  fbus,
  output logic                  busy
);

  localparam int            CW   = $clog2(NUM_CH + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_CH);

  logic       is_code, is_term, is_skip, is_bad;
  logic [1:0] cls_code;

  ascii_char_classify #(
    .TERM_CHAR (TERM_CHAR),
    .SKIP_CHAR (SKIP_CHAR),
    .MODE_CHAR (MODE_CHAR)
  ) u_classify (
    .data    (fbus.rx_data),
    .is_code (is_code),
    .is_term (is_term),
    .is_skip (is_skip),
    .is_bad  (is_bad),
    .code    (cls_code)
  );

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    cause_reg, cause_next;
  logic          overrun_reg, overrun_next;
  logic          err_reg, err_next;
  logic [1:0]    err_cause_reg, err_cause_next;
  logic          wr_en;
  logic [CW-1:0] wr_idx;
  logic          overrun_hit;
  logic [1:0]    slot_reg [NUM_CH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      cause_reg     <= ERR_NONE;
      overrun_reg   <= 1'b0;
      err_reg       <= 1'b0;
      err_cause_reg <= ERR_NONE;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      cause_reg     <= cause_next;
      overrun_reg   <= overrun_next;
      err_reg       <= err_next;
      err_cause_reg <= err_cause_next;
    end
  end

  // Slot storage. Slots beyond the current line length keep stale codes;
  // only a line of exactly NUM_CH codes ever reaches HOLD, so they are
  // always overwritten before being presented.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        slot_reg[gi] <= CODE_ZERO;
      end else if (wr_en && (wr_idx == CW'(gi))) begin
        slot_reg[gi] <= cls_code;
      end
    end
    assign fbus.frame_data[2*gi +: 2] = slot_reg[gi];
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    cause_next     = cause_reg;
    overrun_next   = overrun_reg;
    err_next       = 1'b0;
    err_cause_next = ERR_NONE;
    wr_en          = 1'b0;
    wr_idx         = count_reg;
    overrun_hit    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A terminator here is a blank line and is ignored.
        if (fbus.rx_valid) begin
          if (is_code) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            count_next = CW'(1);
            state_next = ST_COLLECT;
          end else if (is_bad) begin
            cause_next = ERR_BADCHAR;
            state_next = ST_FLUSH;
          end
        end
      end
      ST_COLLECT: begin
        if (fbus.rx_valid) begin
          if (is_code) begin
            if (count_reg == FULL) begin
              cause_next = ERR_LENGTH;
              count_next = '0;
              state_next = ST_FLUSH;
            end else begin
              wr_en      = 1'b1;
              count_next = count_reg + CW'(1);
            end
          end else if (is_bad) begin
            cause_next = ERR_BADCHAR;
            count_next = '0;
            state_next = ST_FLUSH;
          end else if (is_term) begin
            count_next = '0;
            if (count_reg == FULL) begin
              overrun_next = 1'b0;
              state_next   = ST_HOLD;
            end else begin
              err_next       = 1'b1;
              err_cause_next = ERR_LENGTH;
              state_next     = ST_IDLE;
            end
          end
        end
      end
      ST_FLUSH: begin
        // The error is reported at the end of the offending line.
        if (fbus.rx_valid && is_term) begin
          err_next       = 1'b1;
          err_cause_next = cause_reg;
          count_next     = '0;
          state_next     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Bytes arriving while a frame is held are dropped; a byte in the
        // handshake cycle itself still counts as overrun.
        overrun_hit = overrun_reg || (fbus.rx_valid && !is_skip);
        if (fbus.rx_valid && !is_skip) begin
          overrun_next = 1'b1;
          cause_next   = ERR_OVERRUN;
        end
        if (fbus.frame_ready) begin
          overrun_next = 1'b0;
          state_next   = overrun_hit ? ST_FLUSH : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    fbus.frame_valid = (state_reg == ST_HOLD);
    fbus.frame_err   = err_reg;
    fbus.err_cause   = err_cause_reg;
    busy             = (state_reg != ST_IDLE);
  end

endmodule

// File: tb/tb_ascii_frame_decoder.sv
// tb_ascii_frame_decoder
//   Directed scenarios followed by randomized lines. A line-level reference
//   model pushes expected frames/errors into a queue; a negedge monitor pops
//   and compares whenever the DUT shows frame_err or frame_valid.
module tb_ascii_frame_decoder;
  import ascii_frame_pkg::*;

  localparam int NUM_CH = 4;
  localparam int FW     = 2 * NUM_CH;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  ascii_frame_decoder_if #(.NUM_CH(NUM_CH)) fbus();

  ascii_frame_decoder #(.NUM_CH(NUM_CH)) dut (
    .clk  (clk),
    .rst  (rst),
    .fbus (fbus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [FW-1:0] data;
    logic [1:0]  cause;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  n_checks = 0;
  int  n_fail   = 0;

  // Reference model state: codes of the current line, a held frame,
  // overrun pending, and discard-until-terminator with its cause.
  logic [1:0] m_line[$];
  bit         m_held, m_ovr, m_disc;
  logic [1:0] m_cause;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [FW-1:0] pack_line();
    logic [FW-1:0] r;
    r = '0;
    foreach (m_line[k]) r[2*k +: 2] = m_line[k];
    return r;
  endfunction

  function automatic void model_reset();
    m_line.delete();
    m_held  = 0;
    m_ovr   = 0;
    m_disc  = 0;
    m_cause = 2'b00;
    exp_q.delete();
  endfunction

  function automatic void model_byte(logic [7:0] b);
    ev_t e;
    if (b == 8'h0D) return;
    if (m_held) begin
      m_ovr = 1;
      return;
    end
    if (m_disc) begin
      if (b == 8'h0A) begin
        e = '{is_err: 1'b1, data: '0, cause: m_cause};
        exp_q.push_back(e);
        m_disc = 0;
      end
      return;
    end
    if (b == 8'h0A) begin
      if (m_line.size() == NUM_CH) begin
        e = '{is_err: 1'b0, data: pack_line(), cause: 2'b00};
        exp_q.push_back(e);
        m_held = 1;
      end else if (m_line.size() != 0) begin
        e = '{is_err: 1'b1, data: '0, cause: 2'b10};
        exp_q.push_back(e);
      end
      m_line.delete();
    end else if (b == 8'h30 || b == 8'h31 || b == 8'h6D) begin
      if (m_line.size() == NUM_CH) begin
        m_disc = 1; m_cause = 2'b10; m_line.delete();
      end else begin
        m_line.push_back(b == 8'h30 ? 2'b00 : (b == 8'h31 ? 2'b01 : 2'b10));
      end
    end else begin
      m_disc = 1; m_cause = 2'b01; m_line.delete();
    end
  endfunction

  function automatic void model_handshake();
    m_held = 0;
    if (m_ovr) begin
      m_ovr = 0; m_disc = 1; m_cause = 2'b11;
    end
  endfunction

  // One clock of stimulus; the model sees the same inputs the DUT samples.
  task automatic cycle(input bit v, input logic [7:0] b, input bit rdy);
    bit was_held;
    @(posedge clk);
    #1;
    fbus.rx_valid    = v;
    fbus.rx_data     = v ? b : 8'h00;
    fbus.frame_ready = rdy;
    was_held = m_held;
    if (v) model_byte(b);
    if (was_held && rdy) model_handshake();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic send_str(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], rdy);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    fbus.rx_valid = 1'b0;
    fbus.frame_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_frame_valid", 64'(fbus.frame_valid), 64'd0);
    chk("rst_frame_err",   64'(fbus.frame_err),   64'd0);
    chk("rst_err_cause",   64'(fbus.err_cause),   64'd0);
    chk("rst_frame_data",  64'(fbus.frame_data),  64'd0);
    chk("rst_busy",        64'(busy),             64'd0);
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (fbus.frame_err) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_err: got cause %0d, expected no event (t=%0t)", fbus.err_cause, $time);
        end else begin
          mon_ev = exp_q.pop_front();
          chk("err_kind",  64'(mon_ev.is_err), 64'd1);
          chk("err_cause", 64'(fbus.err_cause), 64'(mon_ev.cause));
        end
      end
      if (fbus.frame_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_frame: got data 0x%0h, expected no event (t=%0t)", fbus.frame_data, $time);
        end else begin
          mon_ev = exp_q[0];
          chk("frame_kind", 64'(mon_ev.is_err), 64'd0);
          chk("frame_data", 64'(fbus.frame_data), 64'(mon_ev.data));
          if (fbus.frame_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fbus.rx_valid = 1'b0;
    fbus.rx_data = 8'h00;
    fbus.frame_ready = 1'b0;
    model_reset();
    pulse_reset();

    // Basic frame, ready withheld for a few cycles
    send_str("01m1\n", 1'b0);
    idle(1, 1'b0);
    chk("latency_valid", 64'(fbus.frame_valid), 64'd1);
    chk("t1_data", 64'(fbus.frame_data), 64'h64);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("t1_valid_drop", 64'(fbus.frame_valid), 64'd0);

    // Short line with CR: length error at LF
    send_str("01\r\n", 1'b1);
    idle(1, 1'b1);
    chk("t2_err", 64'(fbus.frame_err), 64'd1);
    chk("t2_cause", 64'(fbus.err_cause), 64'd2);

    // Bad character, then a good frame
    send_str("0x11\n", 1'b1);
    send_str("1111\n", 1'b1);
    idle(2, 1'b1);

    // Too many codes, then blank line
    send_str("00000\n", 1'b1);
    send_str("\n", 1'b1);
    idle(1, 1'b1);
    chk("t4_blank_err", 64'(fbus.frame_err), 64'd0);
    chk("t4_blank_busy", 64'(busy), 64'd0);

    // Overrun while holding
    send_str("1m0m\n", 1'b0);
    idle(1, 1'b0);
    chk("t5_held_data", 64'(fbus.frame_data), 64'h89);
    send_str("11", 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("t5_valid_drop", 64'(fbus.frame_valid), 64'd0);
    chk("t5_busy_flush", 64'(busy), 64'd1);
    send_str("11\n", 1'b1);
    idle(2, 1'b1);

    // Reset mid-frame
    send_str("01", 1'b1);
    pulse_reset();
    send_str("0000\n", 1'b1);
    idle(3, 1'b1);

    // Randomized lines
    for (int ln = 0; ln < 80; ln++) begin
      int len;
      int r;
      logic [7:0] b;
      len = ($urandom_range(0, 1) == 1) ? NUM_CH : int'($urandom_range(0, NUM_CH + 2));
      for (int c = 0; c < len; c++) begin
        r = $urandom_range(0, 99);
        if (r < 30)      b = 8'h30;
        else if (r < 60) b = 8'h31;
        else if (r < 88) b = 8'h6D;
        else if (r < 94) b = 8'h0D;
        else             b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 2) == 0) idle(1, $urandom_range(0, 2) == 0);
        cycle(1'b1, b, $urandom_range(0, 2) == 0);
      end
      cycle(1'b1, 8'h0A, $urandom_range(0, 2) == 0);
      idle($urandom_range(0, 3), $urandom_range(0, 2) == 0);
    end

    // Drain outstanding events
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
